// File: rtl/ldst_router_pkg.sv
// Shared types for the load/store router: pointer/word types, FSM states and the
// request record used by both the issue latch and the holding buffer.
package ldst_router_pkg;

    localparam int PTR_W  = 30;
    localparam int WORD_W = 32;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [WORD_W-1:0] word;

    typedef enum logic [1:0] {
        ROUTER_IDLE,
        ROUTER_WAIT,
        ROUTER_FAULT
    } ldst_router_state;

    typedef struct packed {
        ptr   addr;
        logic write;
        word  data;
    } ldst_req;

    // Index width that stays legal when there is only one port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldst_decode.sv
// Combinational address-window matcher: lowest-indexed matching port wins and its
// window bits are stripped to form the port-local address.
module ldst_decode
    import ldst_router_pkg::*;
#(
    parameter int                           NUM_PORTS = 2,
    parameter logic [PTR_W*NUM_PORTS-1:0]   PORT_BASE = '0,
    parameter logic [PTR_W*NUM_PORTS-1:0]   PORT_MASK = '0,
    localparam int                          IDX_W     = idx_width(NUM_PORTS)
) (
    input  ptr               addr,
    output logic             hit,
    output logic [IDX_W-1:0] index,
    output ptr               local_addr
);

    logic [NUM_PORTS-1:0] match;
    ptr                   local_k [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_match
            localparam ptr BASE_K = PORT_BASE[gi*PTR_W +: PTR_W];
            localparam ptr MASK_K = PORT_MASK[gi*PTR_W +: PTR_W];
            assign match[gi]   = ((addr & MASK_K) == (BASE_K & MASK_K));
            assign local_k[gi] = addr & ~MASK_K;
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit        = |match;
        index      = '0;
        local_addr = addr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (match[k]) begin
                index      = IDX_W'(k);
                local_addr = local_k[k];
            end
        end
    end

endmodule

// File: rtl/ldst_router.sv
// Routes one CPU load/store port to NUM_PORTS slaves by address window, with a
// one-entry holding buffer, fault responses for unmapped addresses and a wait timeout.
module ldst_router
    import ldst_router_pkg::*;
#(
    parameter int                         NUM_PORTS      = 2,
    parameter logic [PTR_W*NUM_PORTS-1:0] PORT_BASE      = {NUM_PORTS{30'h0}},
    parameter logic [PTR_W*NUM_PORTS-1:0] PORT_MASK      = {NUM_PORTS{30'h0}},
    parameter int                         TIMEOUT_CYCLES = 1024,
    parameter int                         FAULT_CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PTR_W-1:0]              in_addr,
    input  logic                          in_start,
    input  logic                          in_write,
    input  logic [WORD_W-1:0]             in_data_wr,
    output logic                          in_ready,
    output logic [WORD_W-1:0]             in_data_rd,
    output logic                          in_fault,
    output logic [PTR_W*NUM_PORTS-1:0]    out_addr,
    output logic [NUM_PORTS-1:0]          out_start,
    output logic                          out_write,
    output logic [WORD_W-1:0]             out_data_wr,
    input  logic [NUM_PORTS-1:0]          out_ready,
    input  logic [WORD_W*NUM_PORTS-1:0]   out_data_rd,
    output logic                          busy,
    output logic                          overflow,
    output logic [FAULT_CNT_W-1:0]        fault_count
);

    localparam int   IDX_W  = idx_width(NUM_PORTS);
    localparam int   CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit   TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    ldst_router_state       state_reg, state_next;
    ldst_req                req_reg, req_next;
    ldst_req                buf_reg, buf_next;
    logic                   buf_valid_reg, buf_valid_next;
    logic [IDX_W-1:0]       sel_reg, sel_next;
    ptr                     local_reg, local_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [NUM_PORTS-1:0]   out_start_reg, out_start_next;
    logic                   in_ready_reg, in_ready_next;
    logic                   in_fault_reg, in_fault_next;
    word                    in_data_rd_reg, in_data_rd_next;
    logic                   overflow_reg, overflow_next;
    logic [FAULT_CNT_W-1:0] fault_count_reg, fault_count_next;

    ldst_req          in_req, src_req;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_index;
    ptr               dec_local;
    word              rd_words [NUM_PORTS];

    assign in_req  = '{addr: in_addr, write: in_write, data: in_data_wr};
    assign src_req = buf_valid_reg ? buf_reg : in_req;

    ldst_decode #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BASE (PORT_BASE),
        .PORT_MASK (PORT_MASK)
    ) u_decode (
        .addr       (src_req.addr),
        .hit        (dec_hit),
        .index      (dec_index),
        .local_addr (dec_local)
    );

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam ptr MASK_K = PORT_MASK[gi*PTR_W +: PTR_W];
            assign rd_words[gi] = out_data_rd[gi*WORD_W +: WORD_W];
            assign out_addr[gi*PTR_W +: PTR_W] =
                (sel_reg == IDX_W'(gi)) ? local_reg : (req_reg.addr & ~MASK_K);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ROUTER_IDLE;
            req_reg         <= '0;
            buf_reg         <= '0;
            buf_valid_reg   <= 1'b0;
            sel_reg         <= '0;
            local_reg       <= '0;
            cnt_reg         <= '0;
            out_start_reg   <= '0;
            in_ready_reg    <= 1'b0;
            in_fault_reg    <= 1'b0;
            in_data_rd_reg  <= '0;
            overflow_reg    <= 1'b0;
            fault_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            buf_reg         <= buf_next;
            buf_valid_reg   <= buf_valid_next;
            sel_reg         <= sel_next;
            local_reg       <= local_next;
            cnt_reg         <= cnt_next;
            out_start_reg   <= out_start_next;
            in_ready_reg    <= in_ready_next;
            in_fault_reg    <= in_fault_next;
            in_data_rd_reg  <= in_data_rd_next;
            overflow_reg    <= overflow_next;
            fault_count_reg <= fault_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        req_next         = req_reg;
        buf_next         = buf_reg;
        buf_valid_next   = buf_valid_reg;
        sel_next         = sel_reg;
        local_next       = local_reg;
        cnt_next         = cnt_reg;
        out_start_next   = '0;
        in_ready_next    = 1'b0;
        in_fault_next    = 1'b0;
        in_data_rd_next  = in_data_rd_reg;
        overflow_next    = overflow_reg;
        fault_count_next = fault_count_reg;

        // Requests arriving while busy go to the buffer, or are lost if it is occupied.
        if (state_reg != ROUTER_IDLE && in_start) begin
            if (!buf_valid_reg) begin
                buf_next       = in_req;
                buf_valid_next = 1'b1;
            end else begin
                overflow_next = 1'b1;
            end
        end

        unique case (state_reg)
            ROUTER_IDLE: begin
                if (buf_valid_reg || in_start) begin
                    // A buffered request goes first; a coincident new one takes its slot.
                    if (buf_valid_reg) begin
                        buf_valid_next = in_start;
                        buf_next       = in_start ? in_req : buf_reg;
                    end
                    if (dec_hit) begin
                        req_next       = src_req;
                        sel_next       = dec_index;
                        local_next     = dec_local;
                        out_start_next = NUM_PORTS'(1) << dec_index;
                        cnt_next       = '0;
                        state_next     = ROUTER_WAIT;
                    end else begin
                        state_next = ROUTER_FAULT;
                    end
                end
            end
            ROUTER_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (TMO_EN && cnt_reg == TMO_LAST) begin
                    in_ready_next   = 1'b1;
                    in_fault_next   = 1'b1;
                    in_data_rd_next = '0;
                    if (fault_count_reg != '1)
                        fault_count_next = fault_count_reg + FAULT_CNT_W'(1);
                    state_next = ROUTER_IDLE;
                end else if (out_ready[sel_reg]) begin
                    in_ready_next   = 1'b1;
                    in_data_rd_next = rd_words[sel_reg];
                    state_next      = ROUTER_IDLE;
                end
            end
            ROUTER_FAULT: begin
                in_ready_next   = 1'b1;
                in_fault_next   = 1'b1;
                in_data_rd_next = '0;
                if (fault_count_reg != '1)
                    fault_count_next = fault_count_reg + FAULT_CNT_W'(1);
                state_next = ROUTER_IDLE;
            end
            default: state_next = ROUTER_IDLE;
        endcase
    end

    assign in_ready    = in_ready_reg;
    assign in_fault    = in_fault_reg;
    assign in_data_rd  = in_data_rd_reg;
    assign out_start   = out_start_reg;
    assign out_write   = req_reg.write;
    assign out_data_wr = req_reg.data;
    assign busy        = (state_reg != ROUTER_IDLE) || buf_valid_reg;
    assign overflow    = overflow_reg;
    assign fault_count = fault_count_reg;

endmodule

// File: tb/tb_ldst_router.sv
// Directed bench for ldst_router: three-port window map, faults, timeout, buffering,
// wrong-port completion and mid-transaction reset, each step with hand-computed values.
module tb_ldst_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] in_addr;
    logic        in_start;
    logic        in_write;
    logic [31:0] in_data_wr;
    logic        in_ready;
    logic [31:0] in_data_rd;
    logic        in_fault;
    logic [89:0] out_addr;
    logic [2:0]  out_start;
    logic        out_write;
    logic [31:0] out_data_wr;
    logic [2:0]  out_ready;
    logic [95:0] out_data_rd;
    logic        busy;
    logic        overflow;
    logic [7:0]  fault_count;

    int errors = 0;
    int checks = 0;
    int seen;

    always #5 clk = ~clk;

    ldst_router #(
        .NUM_PORTS      (3),
        .PORT_BASE      ({30'h20000000, 30'h10000000, 30'h00000000}),
        .PORT_MASK      ({30'h3F000000, 30'h3F000000, 30'h30000000}),
        .TIMEOUT_CYCLES (16),
        .FAULT_CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_addr     (in_addr),
        .in_start    (in_start),
        .in_write    (in_write),
        .in_data_wr  (in_data_wr),
        .in_ready    (in_ready),
        .in_data_rd  (in_data_rd),
        .in_fault    (in_fault),
        .out_addr    (out_addr),
        .out_start   (out_start),
        .out_write   (out_write),
        .out_data_wr (out_data_wr),
        .out_ready   (out_ready),
        .out_data_rd (out_data_rd),
        .busy        (busy),
        .overflow    (overflow),
        .fault_count (fault_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_addr = '0; in_start = 0; in_write = 0; in_data_wr = '0;
        out_ready = '0; out_data_rd = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_start", 64'(out_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fault_count", 64'(fault_count), 64'd0);
        chk("rst_out_addr_lo", 64'(out_addr[59:0]), 64'd0);

        // Mapped load to port 1
        in_addr = 30'h10000040; in_write = 0; in_start = 1;
        tick(); in_start = 0;
        chk("ld1_out_start", 64'(out_start), 64'b010);
        chk("ld1_out_addr1", 64'(out_addr[59:30]), 64'h40);
        chk("ld1_busy", 64'(busy), 64'd1);
        out_ready = 3'b010; out_data_rd[63:32] = 32'hDEADBEEF;
        tick(); out_ready = '0;
        chk("ld1_in_ready", 64'(in_ready), 64'd1);
        chk("ld1_data", 64'(in_data_rd), 64'hDEADBEEF);
        chk("ld1_fault", 64'(in_fault), 64'd0);
        tick();
        chk("ld1_ready_once", 64'(in_ready), 64'd0);
        $display("txn load  addr=10000040 port=1 data=%08h", in_data_rd);

        // Unmapped store
        in_addr = 30'h30000000; in_write = 1; in_data_wr = 32'h12345678; in_start = 1;
        tick(); in_start = 0;
        chk("um_no_start", 64'(out_start), 64'd0);
        chk("um_no_ready_yet", 64'(in_ready), 64'd0);
        tick();
        chk("um_in_ready", 64'(in_ready), 64'd1);
        chk("um_fault", 64'(in_fault), 64'd1);
        chk("um_data", 64'(in_data_rd), 64'd0);
        chk("um_fault_count", 64'(fault_count), 64'd1);
        chk("um_no_start2", 64'(out_start), 64'd0);
        $display("txn store addr=30000000 unmapped fault=%0b", in_fault);
        tick();
        chk("um_ready_once", 64'(in_ready), 64'd0);

        // Port 2 never answers: timeout 16 cycles after out_start
        in_addr = 30'h20000100; in_write = 0; in_start = 1;
        tick(); in_start = 0;
        chk("to_out_start", 64'(out_start), 64'b100);
        chk("to_out_addr2", 64'(out_addr[89:60]), 64'h100);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (in_ready) seen++;
        end
        chk("to_no_early_ready", 64'(seen), 64'd0);
        tick();
        chk("to_in_ready", 64'(in_ready), 64'd1);
        chk("to_fault", 64'(in_fault), 64'd1);
        chk("to_data", 64'(in_data_rd), 64'd0);
        chk("to_fault_count", 64'(fault_count), 64'd2);
        $display("txn load  addr=20000100 port=2 timeout fault=%0b", in_fault);
        out_ready = 3'b100; out_data_rd[95:64] = 32'h55555555;
        tick(); out_ready = '0;
        chk("to_late_ready1", 64'(in_ready), 64'd0);
        tick();
        chk("to_late_ready2", 64'(in_ready), 64'd0);
        chk("to_idle", 64'(busy), 64'd0);

        // Three back-to-back requests: issue, buffer, drop
        in_addr = 30'h10000001; in_start = 1;
        tick();
        chk("bb_first_start", 64'(out_start), 64'b010);
        in_addr = 30'h20000002;
        tick();
        chk("bb_no_overflow_yet", 64'(overflow), 64'd0);
        in_addr = 30'h00000003;
        tick(); in_start = 0;
        chk("bb_overflow", 64'(overflow), 64'd1);
        chk("bb_busy", 64'(busy), 64'd1);
        out_ready = 3'b010; out_data_rd[63:32] = 32'hCAFE0001;
        tick(); out_ready = '0;
        chk("bb_first_ready", 64'(in_ready), 64'd1);
        chk("bb_first_data", 64'(in_data_rd), 64'hCAFE0001);
        $display("txn load  addr=10000001 port=1 data=%08h", in_data_rd);
        tick();
        chk("bb_second_start", 64'(out_start), 64'b100);
        chk("bb_second_addr", 64'(out_addr[89:60]), 64'h2);
        chk("bb_second_no_ready", 64'(in_ready), 64'd0);
        out_ready = 3'b100; out_data_rd[95:64] = 32'hBEEF0002;
        tick(); out_ready = '0;
        chk("bb_second_ready", 64'(in_ready), 64'd1);
        chk("bb_second_data", 64'(in_data_rd), 64'hBEEF0002);
        $display("txn load  addr=20000002 port=2 data=%08h (buffered)", in_data_rd);
        tick();
        chk("bb_third_dropped", 64'(out_start), 64'd0);
        chk("bb_idle", 64'(busy), 64'd0);
        chk("bb_overflow_sticky", 64'(overflow), 64'd1);

        // Completion on the wrong port, then reset mid-WAIT
        in_addr = 30'h10000080; in_start = 1;
        tick(); in_start = 0;
        chk("wp_out_start", 64'(out_start), 64'b010);
        out_ready = 3'b001; out_data_rd[31:0] = 32'h0BADF00D;
        tick(); out_ready = '0;
        chk("wp_no_ready1", 64'(in_ready), 64'd0);
        tick();
        chk("wp_no_ready2", 64'(in_ready), 64'd0);
        chk("wp_still_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("mr_in_ready", 64'(in_ready), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_overflow", 64'(overflow), 64'd0);
        chk("mr_fault_count", 64'(fault_count), 64'd0);
        chk("mr_out_addr", 64'(out_addr[59:30]), 64'd0);
        chk("mr_out_start", 64'(out_start), 64'd0);
        out_ready = 3'b010;
        tick(); out_ready = '0;
        chk("mr_stray1", 64'(in_ready), 64'd0);
        tick();
        chk("mr_stray2", 64'(in_ready), 64'd0);
        $display("txn load  addr=10000080 abandoned by reset");

        // Port 0 window only: store to 0x00000010
        in_addr = 30'h00000010; in_write = 1; in_data_wr = 32'hA5A5A5A5; in_start = 1;
        tick(); in_start = 0;
        chk("p0_out_start", 64'(out_start), 64'b001);
        chk("p0_out_addr0", 64'(out_addr[29:0]), 64'h10);
        chk("p0_out_write", 64'(out_write), 64'd1);
        chk("p0_out_data_wr", 64'(out_data_wr), 64'hA5A5A5A5);
        out_ready = 3'b001; out_data_rd[31:0] = 32'h00000000;
        tick(); out_ready = '0;
        chk("p0_in_ready", 64'(in_ready), 64'd1);
        chk("p0_fault", 64'(in_fault), 64'd0);
        $display("txn store addr=00000010 port=0 ok");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
